// File: rtl/tc_mem_sched_pkg.sv
// rtl/tc_mem_sched_pkg.sv - shared types and constants for the tensor-core memory sequencer
//
// Beat geometry, AXI request/response structs, operand tags, tile configuration and the
// sequencer state encoding. Imported by tc_burst_len_lut and tc_mem_sched.
package tc_mem_sched_pkg;

    localparam int DATA_W     = 256;
    localparam int IDX_W      = 6;
    localparam int ADDR_W     = 32;
    localparam int BN_W       = 8;
    localparam int BEAT_BYTES = DATA_W / 8;

    localparam logic [2:0] AXI_BURST_SIZE = 3'd5;

    localparam logic [2:0] SEL_A = 3'b100;
    localparam logic [2:0] SEL_B = 3'b010;
    localparam logic [2:0] SEL_C = 3'b001;
    localparam logic [2:0] SEL_D = 3'b000;

    // 2'b11 is not a legal shape; it is named so it can be decoded and flagged.
    typedef enum logic [1:0] {
        SHAPE_M16K16N16 = 2'b00,
        SHAPE_M32K16N8  = 2'b01,
        SHAPE_M8K16N32  = 2'b10,
        SHAPE_ILLEGAL   = 2'b11
    } shape_t;

    // Encoding equals log2(32 bits / element bits), used directly as a shift amount.
    typedef enum logic [1:0] {
        DT_FP32 = 2'd0,
        DT_FP16 = 2'd1,
        DT_INT8 = 2'd2,
        DT_INT4 = 2'd3
    } dtype_t;

    typedef enum logic [1:0] {
        MAT_A = 2'd0,
        MAT_B = 2'd1,
        MAT_C = 2'd2,
        MAT_D = 2'd3
    } mat_t;

    typedef struct packed {
        shape_t shape;
        dtype_t dtype;
    } compute_type_t;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] b;
        logic [ADDR_W-1:0] c;
        logic [ADDR_W-1:0] d;
    } baseaddr_t;

    typedef struct packed {
        logic              arready;
        logic              valid;
        logic              finish;
        logic [DATA_W-1:0] data;
    } AXI_in_t;

    typedef struct packed {
        logic              request_valid;
        logic [ADDR_W-1:0] BASE;
        logic              issend;
        logic [2:0]        sel;
        logic [BN_W-1:0]   burst_num;
        logic [2:0]        burst_size;
    } AXI_out_t;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_REQ_C   = 4'd1,
        ST_DAT_C   = 4'd2,
        ST_REQ_A   = 4'd3,
        ST_DAT_A   = 4'd4,
        ST_REQ_B   = 4'd5,
        ST_DAT_B   = 4'd6,
        ST_WAIT_WB = 4'd7,
        ST_REQ_D   = 4'd8,
        ST_DAT_D   = 4'd9
    } sched_state_t;

    function automatic logic [2:0] sel_of(input mat_t m);
        case (m)
            MAT_A:   sel_of = SEL_A;
            MAT_B:   sel_of = SEL_B;
            MAT_C:   sel_of = SEL_C;
            default: sel_of = SEL_D;
        endcase
    endfunction

endpackage

// File: rtl/tc_mem_sched_burst_len_lut.sv
// rtl/tc_mem_sched_burst_len_lut.sv - burst length (arlen) lookup per operand matrix
//
// Ports:
//   cfg       in   tile shape and element type
//   mat       in   operand being transferred (A, B, C or D)
//   burst_num out  beats-1 for that operand
// A carries M*16 elements and B 16*N elements at the element width; C and D are always
// 256 fp32 elements (32 beats). The illegal shape encoding decodes as M16K16N16.
module tc_burst_len_lut
    import tc_mem_sched_pkg::*;
(
    input  compute_type_t   cfg,
    input  mat_t            mat,
    output logic [BN_W-1:0] burst_num
);

    logic [5:0]      m_dim;
    logic [5:0]      n_dim;
    logic [BN_W-1:0] beats;

    always_comb begin
        m_dim = 6'd16;
        n_dim = 6'd16;
        case (cfg.shape)
            SHAPE_M32K16N8: begin m_dim = 6'd32; n_dim = 6'd8;  end
            SHAPE_M8K16N32: begin m_dim = 6'd8;  n_dim = 6'd32; end
            default:        begin m_dim = 6'd16; n_dim = 6'd16; end
        endcase

        // dim*16 elements * (32 >> dtype) bits / 256 bits per beat = (2*dim) >> dtype
        case (mat)
            MAT_A:   beats = {1'b0, m_dim, 1'b0} >> cfg.dtype;
            MAT_B:   beats = {1'b0, n_dim, 1'b0} >> cfg.dtype;
            default: beats = 8'd32;
        endcase

        burst_num = beats - 8'd1;
    end

endmodule

// File: rtl/tc_mem_sched.sv
// rtl/tc_mem_sched.sv - memory-transfer sequencer for one tensor-core tile op
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, cfg, base  op launch; cfg/base latched when start is accepted (idle only)
//   axi_in / axi_out  response from / request to the AXI master shim
//   axi_wdata         D write beat (mirrors wb_data)
//   beat_*            registered read beat with matrix tag and 0-based index
//   wb_req, wb_data   result side has D ready / current D beat
//   wb_pop            D beat consumed this cycle
//   busy, done, err   op in flight / end-of-op pulse / sticky protocol error
// Order of transfers: C, A, B reads, then D writeback once wb_req has been seen.
// Optional build macro TC_MEM_SCHED_CHK_EN enables protocol checking on err and rejects
// the illegal shape at start; without it err stays 0 and the shape decodes as M16K16N16.
module tc_mem_sched
    import tc_mem_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  compute_type_t     cfg,
    input  baseaddr_t         base,
    input  AXI_in_t           axi_in,
    output AXI_out_t          axi_out,
    output logic [DATA_W-1:0] axi_wdata,
    output logic              beat_valid,
    output logic [DATA_W-1:0] beat_data,
    output mat_t              beat_mat,
    output logic [IDX_W-1:0]  beat_idx,
    input  logic              wb_req,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_pop,
    output logic              busy,
    output logic              done,
    output logic              err
);

    sched_state_t      state_q, state_d;
    compute_type_t     cfg_q, cfg_d;
    baseaddr_t         base_q, base_d;
    logic [IDX_W-1:0]  count_q, count_d;
    logic              wb_seen_q, wb_seen_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              beat_valid_q, beat_valid_d;
    logic [DATA_W-1:0] beat_data_q, beat_data_d;
    mat_t              beat_mat_q, beat_mat_d;
    logic [IDX_W-1:0]  beat_idx_q, beat_idx_d;

    logic              is_req;
    logic              is_dat;
    mat_t              cur_mat;
    logic [ADDR_W-1:0] cur_base;
    logic [BN_W-1:0]   cur_bn;
    logic              phase_open;
    logic              acc;
    logic              last_beat;
    logic              illegal_shape;
    logic              chk_fire;

    tc_burst_len_lut u_lut (
        .cfg       (cfg_q),
        .mat       (cur_mat),
        .burst_num (cur_bn)
    );

    always_comb begin
        is_req  = 1'b0;
        is_dat  = 1'b0;
        cur_mat = MAT_C;
        case (state_q)
            ST_REQ_C: begin is_req = 1'b1; cur_mat = MAT_C; end
            ST_DAT_C: begin is_dat = 1'b1; cur_mat = MAT_C; end
            ST_REQ_A: begin is_req = 1'b1; cur_mat = MAT_A; end
            ST_DAT_A: begin is_dat = 1'b1; cur_mat = MAT_A; end
            ST_REQ_B: begin is_req = 1'b1; cur_mat = MAT_B; end
            ST_DAT_B: begin is_dat = 1'b1; cur_mat = MAT_B; end
            ST_REQ_D: begin is_req = 1'b1; cur_mat = MAT_D; end
            ST_DAT_D: begin is_dat = 1'b1; cur_mat = MAT_D; end
            default:  begin is_req = 1'b0; is_dat = 1'b0; cur_mat = MAT_C; end
        endcase

        case (cur_mat)
            MAT_A:   cur_base = base_q.a;
            MAT_B:   cur_base = base_q.b;
            MAT_C:   cur_base = base_q.c;
            default: cur_base = base_q.d;
        endcase
    end

    // A beat arriving in the same cycle the request is accepted belongs to the data phase.
    assign phase_open = is_dat || (is_req && axi_in.arready);
    assign acc        = phase_open && axi_in.valid;
    assign last_beat  = acc && (count_q == cur_bn[IDX_W-1:0]);

`ifdef TC_MEM_SCHED_CHK_EN
    always_comb begin
        illegal_shape = (cfg.shape == SHAPE_ILLEGAL);
        chk_fire = ((state_q == ST_IDLE) && start && illegal_shape)
                || (axi_in.valid && !phase_open)
                || (axi_in.finish && !last_beat)
                || (last_beat && !axi_in.finish);
    end
`else
    logic unused_finish;
    assign unused_finish = axi_in.finish;
    always_comb begin
        illegal_shape = 1'b0;
        chk_fire      = 1'b0;
    end
`endif

    always_comb begin
        state_d      = state_q;
        cfg_d        = cfg_q;
        base_d       = base_q;
        count_d      = count_q;
        wb_seen_d    = wb_seen_q;
        done_d       = 1'b0;
        err_d        = err_q | chk_fire;
        beat_valid_d = 1'b0;
        beat_data_d  = beat_data_q;
        beat_mat_d   = beat_mat_q;
        beat_idx_d   = beat_idx_q;

        // Writeback readiness may arrive at any point during the op; remember it.
        if ((state_q != ST_IDLE) && wb_req) begin
            wb_seen_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start && !illegal_shape) begin
                    state_d   = ST_REQ_C;
                    cfg_d     = cfg;
                    base_d    = base;
                    count_d   = '0;
                    wb_seen_d = 1'b0;
                end
            end
            ST_REQ_C:   if (axi_in.arready) state_d = ST_DAT_C;
            ST_REQ_A:   if (axi_in.arready) state_d = ST_DAT_A;
            ST_REQ_B:   if (axi_in.arready) state_d = ST_DAT_B;
            ST_REQ_D:   if (axi_in.arready) state_d = ST_DAT_D;
            ST_WAIT_WB: if (wb_seen_q || wb_req) state_d = ST_REQ_D;
            default: ;
        endcase

        if (acc) begin
            count_d = count_q + IDX_W'(1);
            if (cur_mat != MAT_D) begin
                beat_valid_d = 1'b1;
                beat_data_d  = axi_in.data;
                beat_mat_d   = cur_mat;
                beat_idx_d   = count_q;
            end
            if (last_beat) begin
                count_d = '0;
                case (cur_mat)
                    MAT_C:   state_d = ST_REQ_A;
                    MAT_A:   state_d = ST_REQ_B;
                    MAT_B:   state_d = (wb_seen_q || wb_req) ? ST_REQ_D : ST_WAIT_WB;
                    default: begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                endcase
            end
        end

        if ((state_d == ST_REQ_D) && (state_q != ST_REQ_D)) begin
            wb_seen_d = 1'b0;
        end
    end

    always_comb begin
        axi_out = '0;
        if (is_req) begin
            axi_out.request_valid = 1'b1;
            axi_out.BASE          = cur_base;
            axi_out.issend        = (cur_mat == MAT_D);
            axi_out.sel           = sel_of(cur_mat);
            axi_out.burst_num     = cur_bn;
            axi_out.burst_size    = AXI_BURST_SIZE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cfg_q        <= '0;
            base_q       <= '0;
            count_q      <= '0;
            wb_seen_q    <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            beat_valid_q <= 1'b0;
            beat_data_q  <= '0;
            beat_mat_q   <= MAT_A;
            beat_idx_q   <= '0;
        end else begin
            state_q      <= state_d;
            cfg_q        <= cfg_d;
            base_q       <= base_d;
            count_q      <= count_d;
            wb_seen_q    <= wb_seen_d;
            done_q       <= done_d;
            err_q        <= err_d;
            beat_valid_q <= beat_valid_d;
            beat_data_q  <= beat_data_d;
            beat_mat_q   <= beat_mat_d;
            beat_idx_q   <= beat_idx_d;
        end
    end

    assign axi_wdata  = wb_data;
    assign wb_pop     = acc && (cur_mat == MAT_D);
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign err        = err_q;
    assign beat_valid = beat_valid_q;
    assign beat_data  = beat_data_q;
    assign beat_mat   = beat_mat_q;
    assign beat_idx   = beat_idx_q;

endmodule

// File: tb/tb_tc_mem_sched.sv
// tb/tb_tc_mem_sched.sv - self-checking bench for tc_mem_sched
module tb_tc_mem_sched;
    import tc_mem_sched_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    compute_type_t     cfg;
    baseaddr_t         base;
    AXI_in_t           axi_in;
    AXI_out_t          axi_out;
    logic [DATA_W-1:0] axi_wdata;
    logic              beat_valid;
    logic [DATA_W-1:0] beat_data;
    mat_t              beat_mat;
    logic [IDX_W-1:0]  beat_idx;
    logic              wb_req = 1'b0;
    logic [DATA_W-1:0] wb_data = '0;
    logic              wb_pop, busy, done, err;

    tc_mem_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cfg        (cfg),
        .base       (base),
        .axi_in     (axi_in),
        .axi_out    (axi_out),
        .axi_wdata  (axi_wdata),
        .beat_valid (beat_valid),
        .beat_data  (beat_data),
        .beat_mat   (beat_mat),
        .beat_idx   (beat_idx),
        .wb_req     (wb_req),
        .wb_data    (wb_data),
        .wb_pop     (wb_pop),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    bit                mon_en = 1'b0;
    bit                drv_rd = 1'b0;
    bit                drv_wr = 1'b0;
    mat_t              drv_mat = MAT_A;
    int                drv_idx = 0;
    logic [DATA_W-1:0] drv_data = '0;
    bit                last_rd = 1'b0;
    mat_t              last_mat = MAT_A;
    int                last_idx = 0;
    logic [DATA_W-1:0] last_data = '0;

`ifdef TC_MEM_SCHED_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    task automatic chk(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Read beats show up registered one cycle after the bench drives them; wb_pop is same-cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("beat_valid", beat_valid, last_rd);
            if (last_rd) begin
                chk("beat_data", beat_data, last_data);
                chk("beat_mat", beat_mat, last_mat);
                chk("beat_idx", beat_idx, last_idx[IDX_W-1:0]);
            end
            chk("wb_pop", wb_pop, drv_wr);
            if (drv_wr) chk("axi_wdata", axi_wdata, wb_data);
            last_rd   = drv_rd;
            last_mat  = drv_mat;
            last_idx  = drv_idx;
            last_data = drv_data;
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        axi_in = '0;
        drv_rd = 1'b0;
        drv_wr = 1'b0;
        start  = 1'b0;
        wb_req = 1'b0;
    endtask

    function automatic logic [DATA_W-1:0] rand256();
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Beats per operand from element counts and element sizes.
    function automatic int model_beats(input compute_type_t c, input mat_t m);
        int md, nd, bits, elems;
        case (c.shape)
            SHAPE_M32K16N8: begin md = 32; nd = 8;  end
            SHAPE_M8K16N32: begin md = 8;  nd = 32; end
            default:        begin md = 16; nd = 16; end
        endcase
        case (c.dtype)
            DT_FP32: bits = 32;
            DT_FP16: bits = 16;
            DT_INT8: bits = 8;
            default: bits = 4;
        endcase
        case (m)
            MAT_A:   elems = md * 16;
            MAT_B:   elems = 16 * nd;
            default: begin elems = 256; bits = 32; end
        endcase
        return (elems * bits / 8) / 32;
    endfunction

    task automatic do_reset();
        mon_en = 1'b0;
        idle_in();
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n   = 1'b1;
        last_rd = 1'b0;
        cycle();
    endtask

    task automatic do_op(input compute_type_t c, input baseaddr_t b, input int bn_a, input int bn_b,
                         input int dly_a, input int wb_phase, input bit same_cyc, input int gap_max,
                         input int abort_beat, input int bad_fin_beat, input bit exp_err);
        mat_t        order [4];
        int          bn    [4];
        logic [31:0] addr  [4];
        logic [2:0]  sel   [4];
        AXI_out_t    exp;
        int          d, g, first;
        order = '{MAT_C, MAT_A, MAT_B, MAT_D};
        bn    = '{31, bn_a, bn_b, 31};
        addr  = '{b.c, b.a, b.b, b.d};
        sel   = '{3'b001, 3'b100, 3'b010, 3'b000};

        idle_in();
        cfg    = c;
        base   = b;
        start  = 1'b1;
        mon_en = 1'b1;
        cycle();
        start = 1'b0;
        cfg   = compute_type_t'($urandom);
        base  = baseaddr_t'({$urandom, $urandom, $urandom, $urandom});

        for (int p = 0; p < 4; p++) begin
            if (p == 3 && wb_phase == 3) begin
                for (int k = 0; k < 4; k++) begin
                    chk("wait_wb_hold", axi_out.request_valid, 1'b0);
                    cycle();
                end
                wb_req = 1'b1;
                cycle();
                wb_req = 1'b0;
            end
            exp               = '0;
            exp.request_valid = 1'b1;
            exp.BASE          = addr[p];
            exp.issend        = (p == 3);
            exp.sel           = sel[p];
            exp.burst_num     = 8'(bn[p]);
            exp.burst_size    = 3'd5;
            chk($sformatf("req_%0d", p), axi_out, exp);
            if (p == 0) chk("busy", busy, 1'b1);

            d = (p == 1) ? dly_a : int'($urandom_range(0, 2));
            for (int k = 0; k < d; k++) begin
                cycle();
                chk($sformatf("req_hold_%0d", p), axi_out, exp);
            end

            axi_in.arready = 1'b1;
            first = 0;
            if (same_cyc && p < 3) begin
                axi_in.valid  = 1'b1;
                axi_in.data   = rand256();
                axi_in.finish = 1'b0;
                drv_rd   = 1'b1;
                drv_mat  = order[p];
                drv_idx  = 0;
                drv_data = axi_in.data;
                if (p == wb_phase) wb_req = 1'b1;
                first = 1;
            end
            cycle();
            axi_in = '0;
            drv_rd = 1'b0;
            wb_req = 1'b0;
            chk($sformatf("req_drop_%0d", p), axi_out.request_valid, 1'b0);

            for (int i = first; i <= bn[p]; i++) begin
                g = $urandom_range(0, gap_max);
                for (int k = 0; k < g; k++) begin
                    axi_in = '0;
                    drv_rd = 1'b0;
                    drv_wr = 1'b0;
                    cycle();
                end
                axi_in.valid  = 1'b1;
                axi_in.data   = rand256();
                axi_in.finish = (i == bn[p]) || (p == 0 && i == bad_fin_beat);
                if (p < 3) begin
                    drv_rd   = 1'b1;
                    drv_mat  = order[p];
                    drv_idx  = i;
                    drv_data = axi_in.data;
                end else begin
                    drv_wr  = 1'b1;
                    wb_data = rand256();
                end
                if (p == wb_phase && i == first) wb_req = 1'b1;
                if (p == 1 && i == first) begin
                    start = 1'b1;
                    cfg   = compute_type_t'($urandom);
                end
                if (p == 1 && i == abort_beat) begin
                    mon_en = 1'b0;
                    #2;
                    rst_n = 1'b0;
                    #1;
                    chk("rst_axi_out", axi_out, '0);
                    chk("rst_beat_valid", beat_valid, 1'b0);
                    chk("rst_beat_idx", beat_idx, '0);
                    chk("rst_wb_pop", wb_pop, 1'b0);
                    chk("rst_busy", busy, 1'b0);
                    chk("rst_done", done, 1'b0);
                    chk("rst_err", err, 1'b0);
                    idle_in();
                    cycle();
                    cycle();
                    chk("rst_hold_req", axi_out.request_valid, 1'b0);
                    rst_n   = 1'b1;
                    last_rd = 1'b0;
                    cycle();
                    return;
                end
                cycle();
                axi_in = '0;
                drv_rd = 1'b0;
                drv_wr = 1'b0;
                wb_req = 1'b0;
                start  = 1'b0;
            end
        end
        chk("done", done, 1'b1);
        chk("busy_end", busy, 1'b0);
        chk("req_end", axi_out.request_valid, 1'b0);
        cycle();
        chk("done_pulse", done, 1'b0);
        chk("err", err, exp_err);
    endtask

    typedef struct {
        compute_type_t cfg;
        baseaddr_t     base;
        int            bn_a;
        int            bn_b;
        int            dly_a;
        int            wb_phase;
        bit            same_cyc;
    } vec_t;

    function automatic vec_t mk(input shape_t s, input dtype_t dt, input int bna, input int bnb,
                                input int dly, input int wbp, input bit sc,
                                input logic [31:0] a, input logic [31:0] bb,
                                input logic [31:0] c, input logic [31:0] dd);
        vec_t v;
        v.cfg.shape = s;
        v.cfg.dtype = dt;
        v.base.a    = a;
        v.base.b    = bb;
        v.base.c    = c;
        v.base.d    = dd;
        v.bn_a      = bna;
        v.bn_b      = bnb;
        v.dly_a     = dly;
        v.wb_phase  = wbp;
        v.same_cyc  = sc;
        return v;
    endfunction

    vec_t vecs [7];
    int   nv;

    initial begin
        compute_type_t rc;
        baseaddr_t     rb;

        vecs[0] = mk(SHAPE_M32K16N8,  DT_FP32, 63, 15, 5, 2, 1'b0, 32'h0,    32'h800,  32'hA00,  32'hE00);
        vecs[1] = mk(SHAPE_M8K16N32,  DT_INT4,  1,  7, 0, 3, 1'b0, 32'h1000, 32'h2000, 32'h3000, 32'h4000);
        vecs[2] = mk(SHAPE_M16K16N16, DT_FP32, 31, 31, 1, 0, 1'b1, 32'h5000, 32'h6040, 32'h7080, 32'h80C0);
        vecs[3] = mk(SHAPE_M16K16N16, DT_FP16, 15, 15, 0, 1, 1'b1, 32'hA000, 32'hB000, 32'hC000, 32'hD000);
        vecs[4] = mk(SHAPE_M8K16N32,  DT_INT8,  3, 15, 2, 3, 1'b0, 32'h100,  32'h200,  32'h300,  32'h400);
        vecs[5] = mk(SHAPE_M32K16N8,  DT_INT4,  7,  1, 0, 2, 1'b1, 32'hF000, 32'hF100, 32'hF200, 32'hF300);
        nv = 6;
`ifndef TC_MEM_SCHED_CHK_EN
        vecs[6] = mk(SHAPE_ILLEGAL,   DT_FP32, 31, 31, 0, 0, 1'b0, 32'h40,   32'h80,   32'hC0,   32'h100);
        nv = 7;
`endif

        idle_in();
        cfg   = '0;
        base  = '0;
        rst_n = 1'b0;
        cycle();
        cycle();
        chk("reset_axi_out", axi_out, '0);
        chk("reset_beat_valid", beat_valid, 1'b0);
        chk("reset_beat_idx", beat_idx, '0);
        chk("reset_wb_pop", wb_pop, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_err", err, 1'b0);
        rst_n = 1'b1;
        cycle();

        for (int i = 0; i < nv; i++) begin
            do_op(vecs[i].cfg, vecs[i].base, vecs[i].bn_a, vecs[i].bn_b, vecs[i].dly_a,
                  vecs[i].wb_phase, vecs[i].same_cyc, 2, -1, -1, 1'b0);
        end

        for (int i = 0; i < 10; i++) begin
            rc.shape = shape_t'(CHK ? $urandom_range(0, 2) : $urandom_range(0, 3));
            rc.dtype = dtype_t'($urandom_range(0, 3));
            rb = baseaddr_t'({$urandom, $urandom, $urandom, $urandom});
            do_op(rc, rb, model_beats(rc, MAT_A) - 1, model_beats(rc, MAT_B) - 1,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  3, -1, -1, 1'b0);
        end

        rc.shape = SHAPE_M16K16N16;
        rc.dtype = DT_FP32;
        rb = baseaddr_t'({32'h11000, 32'h12000, 32'h13000, 32'h14000});
        do_op(rc, rb, 31, 31, 0, 0, 1'b0, 1, 10, -1, 1'b0);
        do_op(rc, rb, 31, 31, 0, 2, 1'b0, 1, -1, -1, 1'b0);

        do_op(rc, rb, 31, 31, 0, 1, 1'b0, 1, -1, 3, CHK);
        cycle();
        chk("err_sticky", err, CHK);
        do_reset();
        chk("err_cleared", err, 1'b0);

`ifdef TC_MEM_SCHED_CHK_EN
        cfg.shape = SHAPE_ILLEGAL;
        cfg.dtype = DT_FP32;
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("illegal_busy", busy, 1'b0);
        chk("illegal_req", axi_out.request_valid, 1'b0);
        chk("illegal_err", err, 1'b1);
        do_reset();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
